fp_addsub_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor.
- Next generation of the team's single-cycle fp_add_2. Adds:
  - per-operation add/sub select
  - round-to-nearest-even
  - special-value handling (zero/inf/NaN) with status flags
  - valid/ready streaming with backpressure
- Feeds the CNN accumulate datapath. Results come out packed, and also split into sign, exponent and mantissa.

---
 rtl/fp_addsub_pipe.sv | 254 +++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage floating-point add/subtract with RNE rounding,
// zero/inf/NaN handling, status flags and valid/ready backpressure.
module fp_addsub_pipe #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   A_FP,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   B_FP,
    input  logic                                     op,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   result,
    output logic                                     sign,
    output logic [EXPONENT_WIDTH-1:0]                exponent,
    output logic [MANTISSA_WIDTH-1:0]                mantissa,
    output logic                                     overflow,
    output logic                                     underflow,
    output logic                                     invalid
);

    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int W  = 1 + E + M;
    localparam int SW = M + 4;
    localparam int XW = 32;

    localparam logic [E-1:0] EONES = '1;
    localparam logic [W-1:0] QNAN  = {1'b0, EONES, 1'b1, {(M-1){1'b0}}};

    // Leading-zero count of the aligned sum (SW when all zero).
    function automatic logic [XW-1:0] lzc_f(input logic [SW-1:0] v);
        lzc_f = XW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) lzc_f = XW'(SW - 1 - i);
        end
    endfunction

    assign in_ready = ~(out_valid & ~out_ready);

    // ---------------- stage 1: unpack, classify, swap ----------------
    logic         a_s, b_s;
    logic [E-1:0] a_e, b_e;
    logic [M-1:0] a_f, b_f;
    logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, b_big;

    assign a_s    = A_FP[W-1];
    assign a_e    = A_FP[W-2:M];
    assign a_f    = A_FP[M-1:0];
    assign b_s    = B_FP[W-1] ^ op;
    assign b_e    = B_FP[W-2:M];
    assign b_f    = B_FP[M-1:0];
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_inf  = (a_e == EONES) & (a_f == '0);
    assign b_inf  = (b_e == EONES) & (b_f == '0);
    assign a_nan  = (a_e == EONES) & (a_f != '0);
    assign b_nan  = (b_e == EONES) & (b_f != '0);
    assign b_big  = {b_e, b_f} > {a_e, a_f};

    logic         c1_special, c1_inv, c1_sign;
    logic [W-1:0] c1_spec;
    logic [E-1:0] c1_exp, c1_diff;
    logic [M:0]   c1_big_sig, c1_sml_sig;

    // Resolve special operands and order the finite ones by magnitude.
    always_comb begin
        c1_special = 1'b1;
        c1_inv     = 1'b0;
        c1_spec    = '0;
        if (a_nan | b_nan | (a_inf & b_inf & (a_s != b_s))) begin
            c1_spec = QNAN;
            c1_inv  = 1'b1;
        end else if (a_inf) begin
            c1_spec = {a_s, a_e, a_f};
        end else if (b_inf) begin
            c1_spec = {b_s, b_e, b_f};
        end else if (a_zero & b_zero) begin
            c1_spec = {a_s & b_s, {(W-1){1'b0}}};
        end else if (a_zero) begin
            c1_spec = {b_s, b_e, b_f};
        end else if (b_zero) begin
            c1_spec = {a_s, a_e, a_f};
        end else begin
            c1_special = 1'b0;
        end
        if (b_big) begin
            c1_sign    = b_s;
            c1_exp     = b_e;
            c1_diff    = b_e - a_e;
            c1_big_sig = {1'b1, b_f};
            c1_sml_sig = {1'b1, a_f};
        end else begin
            c1_sign    = a_s;
            c1_exp     = a_e;
            c1_diff    = a_e - b_e;
            c1_big_sig = {1'b1, a_f};
            c1_sml_sig = {1'b1, b_f};
        end
    end

    logic         s1_valid, s1_special, s1_inv, s1_sign, s1_sub;
    logic [W-1:0] s1_spec;
    logic [E-1:0] s1_exp, s1_diff;
    logic [M:0]   s1_big_sig, s1_sml_sig;

    // Stage 1 register; holds while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_special <= 1'b0;
            s1_inv     <= 1'b0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_spec    <= '0;
            s1_exp     <= '0;
            s1_diff    <= '0;
            s1_big_sig <= '0;
            s1_sml_sig <= '0;
        end else if (in_ready) begin
            s1_valid   <= in_valid;
            s1_special <= c1_special;
            s1_inv     <= c1_inv;
            s1_sign    <= c1_sign;
            s1_sub     <= a_s ^ b_s;
            s1_spec    <= c1_spec;
            s1_exp     <= c1_exp;
            s1_diff    <= c1_diff;
            s1_big_sig <= c1_big_sig;
            s1_sml_sig <= c1_sml_sig;
        end
    end

    // ---------------- stage 2: align and add ----------------
    logic [2*SW-1:0] wide;
    logic [SW-1:0]   aligned;
    logic [SW:0]     sum_c;

    // Shift the small significand right, folding lost bits into sticky.
    always_comb begin
        wide = {s1_sml_sig, 3'b000, {SW{1'b0}}} >> s1_diff;
        if (int'(s1_diff) >= M + 3) begin
            aligned = SW'(1);
        end else begin
            aligned = wide[2*SW-1:SW] | SW'(|wide[SW-1:0]);
        end
        if (s1_sub) begin
            sum_c = {1'b0, s1_big_sig, 3'b000} - {1'b0, aligned};
        end else begin
            sum_c = {1'b0, s1_big_sig, 3'b000} + {1'b0, aligned};
        end
    end

    logic         s2_valid, s2_special, s2_inv, s2_sign;
    logic [W-1:0] s2_spec;
    logic [E-1:0] s2_exp;
    logic [SW:0]  s2_sum;

    // Stage 2 register; holds while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_special <= 1'b0;
            s2_inv     <= 1'b0;
            s2_sign    <= 1'b0;
            s2_spec    <= '0;
            s2_exp     <= '0;
            s2_sum     <= '0;
        end else if (in_ready) begin
            s2_valid   <= s1_valid;
            s2_special <= s1_special;
            s2_inv     <= s1_inv;
            s2_sign    <= s1_sign;
            s2_spec    <= s1_spec;
            s2_exp     <= s1_exp;
            s2_sum     <= sum_c;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [SW-1:0]        norm;
    logic [XW-1:0]        lz;
    logic signed [XW-1:0] e_n, e_f;
    logic                 rnd_up, c3_ov, c3_un;
    logic [M+1:0]         mant_r;
    logic [M-1:0]         frac_f;
    logic [W-1:0]         c3_res;

    // Normalise, apply round-to-nearest-even, then range-check exponent.
    always_comb begin
        c3_ov  = 1'b0;
        c3_un  = 1'b0;
        lz     = lzc_f(s2_sum[SW-1:0]);
        e_n    = $signed(XW'(s2_exp));
        if (s2_sum[SW]) begin
            norm = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
            e_n  = e_n + 1;
        end else begin
            norm = s2_sum[SW-1:0] << lz;
            e_n  = e_n - $signed(lz);
        end
        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, norm[SW-1:3]} + (M+2)'(rnd_up);
        e_f    = e_n;
        frac_f = mant_r[M-1:0];
        if (mant_r[M+1]) begin
            e_f    = e_n + 1;
            frac_f = mant_r[M:1];
        end
        if (s2_sum == '0) begin
            c3_res = '0;
        end else if (e_f >= $signed(XW'(EONES))) begin
            c3_res = {s2_sign, EONES, {M{1'b0}}};
            c3_ov  = 1'b1;
        end else if (e_f <= 0) begin
            c3_res = {s2_sign, {(W-1){1'b0}}};
            c3_un  = 1'b1;
        end else begin
            c3_res = {s2_sign, e_f[E-1:0], frac_f};
        end
    end

    // Output register; bubbles clear result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result    <= s2_special ? s2_spec : c3_res;
                overflow  <= ~s2_special & c3_ov;
                underflow <= ~s2_special & c3_un;
                invalid   <= s2_special & s2_inv;
            end else begin
                result    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
                invalid   <= 1'b0;
            end
        end
    end

    assign sign     = result[W-1];
    assign exponent = result[W-2:M];
    assign mantissa = result[M-1:0];

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: scoreboard bench for fp_addsub_pipe with an
// integer-arithmetic reference model and random backpressure.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] A_FP, B_FP, result;
    logic        sign, overflow, underflow, invalid;
    logic [7:0]  exponent;
    logic [22:0] mantissa;

    fp_addsub_pipe #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A_FP(A_FP), .B_FP(B_FP), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .sign(sign),
        .exponent(exponent), .mantissa(mantissa), .overflow(overflow),
        .underflow(underflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [34:0] sb[$];
    logic        use_dir;
    logic [34:0] dir_exp;
    logic        held;
    logic [34:0] held_val, mon_exp;
    bit          rdone;

    task automatic chk(input string nm, input logic [34:0] got,
                       input logic [34:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, want);
        end
    endtask

    function automatic longint unsigned shr_sticky(
        input longint unsigned v, input int d);
        longint unsigned r;
        if (d == 0) return v;
        if (d >= 63) return (v != 0) ? 64'd1 : 64'd0;
        r = v >> d;
        if ((r << d) != v) r = r | 64'd1;
        return r;
    endfunction

    // Reference: exact-ish signed integer sum, then RNE to 24 bits.
    function automatic logic [34:0] ref_model(input logic [31:0] a,
        input logic [31:0] b, input logic o);
        logic            sa, sb2, rs;
        int              ea, eb, emax, p, e, sh;
        logic [22:0]     fa, fb;
        longint unsigned x, y, mag, keep, rem, half;
        longint          t;
        sa  = a[31];
        sb2 = b[31] ^ o;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        fa  = a[22:0];
        fb  = b[22:0];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
            (ea == 255 && eb == 255 && sa != sb2))
            return {32'h7FC00000, 3'b001};
        if (ea == 255) return {sa, 8'hFF, 23'h0, 3'b000};
        if (eb == 255) return {sb2, 8'hFF, 23'h0, 3'b000};
        if (ea == 0 && eb == 0) return {sa & sb2, 31'h0, 3'b000};
        if (ea == 0) return {sb2, b[30:0], 3'b000};
        if (eb == 0) return {a, 3'b000};
        emax = (ea > eb) ? ea : eb;
        x = shr_sticky({8'h0, 1'b1, fa, 32'h0}, emax - ea);
        y = shr_sticky({8'h0, 1'b1, fb, 32'h0}, emax - eb);
        t = sa ? -longint'(x) : longint'(x);
        t = t + (sb2 ? -longint'(y) : longint'(y));
        if (t == 0) return 35'h0;
        rs  = (t < 0);
        mag = rs ? -t : t;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        e    = emax + p - 55;
        sh   = p - 23;
        keep = mag >> sh;
        rem  = mag & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {rs, 8'hFF, 23'h0, 3'b100};
        if (e <= 0) return {rs, 31'h0, 3'b010};
        return {rs, 8'(e), keep[22:0], 3'b000};
    endfunction

    function automatic logic [31:0] rand_fp(input int near);
        int          k, e;
        logic [22:0] f;
        k = int'($urandom_range(0, 19));
        f = ($urandom_range(0, 5) == 0) ? 23'h0 : 23'($urandom);
        if (k == 0) e = 0;
        else if (k == 1) e = 255;
        else if (k < 10) e = near + int'($urandom_range(0, 6)) - 3;
        else e = int'($urandom_range(1, 254));
        if (k >= 2 && e < 1) e = 1;
        if (k >= 2 && e > 254) e = 254;
        if (k == 1 && $urandom_range(0, 2) != 0) f = 23'h0;
        return {1'($urandom), 8'(e), f};
    endfunction

    function automatic int rand_near();
        if ($urandom_range(0, 3) == 0)
            return ($urandom_range(0, 1) != 0) ? 253 : 2;
        return int'($urandom_range(1, 254));
    endfunction

    // Push the expected response at the accepting edge.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            sb.push_back(use_dir ? dir_exp : ref_model(A_FP, B_FP, op));
    end

    // Monitor: pop/compare on transfer, stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (held)
                chk("stall_stable", {result, overflow, underflow, invalid},
                    held_val);
            if (out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    chk("sb_empty", 35'd1, 35'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("result", {result, overflow, underflow, invalid},
                        mon_exp);
                    chk("split", {sign, exponent, mantissa, 3'b000},
                        {mon_exp[34:3], 3'b000});
                end
            end else begin
                held     = 1'b1;
                held_val = {result, overflow, underflow, invalid};
            end
        end else begin
            held = 1'b0;
            chk("idle_flags", {32'h0, overflow, underflow, invalid}, 35'h0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic dir,
                        input logic [34:0] de);
        bit done;
        done     = 1'b0;
        A_FP     = a;
        B_FP     = b;
        op       = o;
        use_dir  = dir;
        dir_exp  = de;
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 35'd0, 35'd1);
    endtask

    task automatic dsend(input logic [31:0] a, input logic [31:0] b,
                         input logic o, input logic [31:0] r,
                         input logic [2:0] fl);
        send(a, b, o, 1'b1, {r, fl});
    endtask

    task automatic check_latency();
        @(negedge clk);
        chk("lat_c1", {34'h0, out_valid}, 35'd0);
        @(negedge clk);
        chk("lat_c2", {34'h0, out_valid}, 35'd0);
        @(negedge clk);
        chk("lat_c3", {34'h0, out_valid}, 35'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 35'(sb.size()), 35'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0;
        A_FP = '0; B_FP = '0; use_dir = 1'b0; dir_exp = '0;
        held = 1'b0; rdone = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_state", {result, overflow, underflow, invalid},
            35'h0);
        chk("rst_ctrl", {33'h0, out_valid, in_ready}, 35'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        dsend(32'h40E80000, 32'h3EC00000, 1'b0, 32'h40F40000, 3'b000);
        check_latency();
        dsend(32'h42820000, 32'h427C0000, 1'b1, 32'h40000000, 3'b000);
        dsend(32'h40800000, 32'h40800000, 1'b1, 32'h00000000, 3'b000);
        dsend(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
        dsend(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000);
        dsend(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001);
        dsend(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100);
        dsend(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010);
        dsend(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        dsend(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
        dsend(32'h00000000, 32'h3FC00000, 1'b1, 32'hBFC00000, 3'b000);
        dsend(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000);
        dsend(32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001);
        dsend(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000);
        dsend(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001);
        drain();

        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    ra = rand_fp(rand_near());
                    rb = rand_fp(int'(ra[30:23]));
                    send(ra, rb, 1'($urandom), 1'b0, 35'h0);
                end
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 30 && !seen; n++) begin
                    @(posedge clk);
                    #1;
                    seen = out_valid;
                end
                if (!seen) chk("bp_wait", 35'd0, 35'd1);
                out_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("bp_in_ready", {33'h0, out_valid, in_ready},
                        35'd2);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) begin
            ra = rand_fp(rand_near());
            rb = rand_fp(int'(ra[30:23]));
            send(ra, rb, 1'($urandom), 1'b0, 35'h0);
        end
        chk("pre_rst_valid", {34'h0, out_valid}, 35'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", {result, overflow, underflow, invalid},
            35'h0);
        chk("async_rst_ctrl", {33'h0, out_valid, in_ready}, 35'd1);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        dsend(32'h40E80000, 32'h3EC00000, 1'b0, 32'h40F40000, 3'b000);
        check_latency();
        drain();

        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = rand_fp(rand_near());
                    rb = rand_fp(int'(ra[30:23]));
                    send(ra, rb, 1'($urandom), 1'b0, 35'h0);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
